// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with frame-aligned data commit.
// Define HEX_DISPLAY_SCANNER_LZB_EN to enable leading-zero blanking via blank_lz.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD_CYCLES);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pend;

  logic                    slot_end, boundary;
  logic [3:0]              nib;
  logic                    dig_dp, digit_blank;
  logic [NUM_DIGITS-1:0]   an_sel, an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses the pending regs so it shows next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend     <= 1'b0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (boundary) begin
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pend) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pend <= 1'b0;
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend     <= 1'b1;
    end
  end

`ifdef HEX_DISPLAY_SCANNER_LZB_EN
  logic higher_zero;
`else
  logic unused_blank_lz;
  assign unused_blank_lz = blank_lz;
`endif

  always_comb begin
    nib         = '0;
    dig_dp      = 1'b0;
    digit_blank = 1'b0;
    an_sel      = '1;
`ifdef HEX_DISPLAY_SCANNER_LZB_EN
    // Walk from the most significant digit down; digit 0 is never a candidate.
    higher_zero = blank_lz;
    for (int unsigned k = NUM_DIGITS; k > 1; k--) begin
      higher_zero = higher_zero && (disp_val[4*(k-1) +: 4] == 4'h0);
      if (idx == IDX_W'(k - 1)) digit_blank = higher_zero;
    end
`endif
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp_val[4*i +: 4];
        dig_dp    = disp_dp[i];
        an_sel[i] = 1'b0;
      end
    end
    if (div_cnt < GUARD_END) begin
      an_next  = '1;
      seg_next = '1;
      dp_next  = 1'b1;
    end else begin
      an_next  = an_sel;
      seg_next = digit_blank ? 7'b1111111 : decode(nib);
      dp_next  = ~dig_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= '1;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_next;
      dp         <= dp_next;
      an         <= an_next;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner (4 digits, 4 cycles/slot, 1 guard cycle).
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int vectors = 0;
  int errors  = 0;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SC  = 7'b0110001;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'b1111111;

  logic [6:0] lz;

  hex_display_scanner #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .GUARD_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " an"},   {3'b000, an},          7'h0F);
    chk({tag, " seg"},  seg,                   OFF);
    chk({tag, " dp"},   {6'b0, dp},            7'h01);
    chk({tag, " tick"}, {6'b0, frame_tick},    7'h00);
  endtask

  // Runs n cycles from a frame start; up to two loads at cycle la / lb (-1 = none).
  task automatic run_frame(input string tag, input int n,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dpm,
                           input int la, input logic [15:0] va, input logic [3:0] da,
                           input int lb, input logic [15:0] vb, input logic [3:0] db);
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         slot;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int j = 0; j < n; j++) begin
      load  = (j == la) || (j == lb);
      value = (j == lb) ? vb : va;
      dp_in = (j == lb) ? db : da;
      @(posedge clk);
      @(negedge clk);
      slot = j / 4;
      if (j % 4 == 0) begin
        exp_an = 4'b1111; exp_seg = OFF; exp_dp = 1'b1;
      end else begin
        exp_an = ~(4'b0001 << slot); exp_seg = segs[slot]; exp_dp = ~dpm[slot];
      end
      chk($sformatf("%s j=%0d an", tag, j),   {3'b000, an},       {3'b000, exp_an});
      chk($sformatf("%s j=%0d seg", tag, j),  seg,                exp_seg);
      chk($sformatf("%s j=%0d dp", tag, j),   {6'b0, dp},         {6'b0, exp_dp});
      chk($sformatf("%s j=%0d tick", tag, j), {6'b0, frame_tick}, {6'b0, (j == 15)});
    end
    load = 1'b0;
  endtask

  initial begin
`ifdef HEX_DISPLAY_SCANNER_LZB_EN
    lz = OFF;
`else
    lz = S0;
`endif
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    run_frame("A", 16, S0, S0, S0, S0, 4'b0000, 6, 16'h8A3F, 4'b0100, -1, 16'h0, 4'b0);
    run_frame("B", 16, SF, S3, SA, S8, 4'b0100, 3, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000);
    blank_lz = 1'b1;
    run_frame("C", 16, S2, S2, S2, S2, 4'b0000, 15, 16'h00C5, 4'b0001, -1, 16'h0, 4'b0);
    run_frame("D", 16, S5, SC, lz, lz, 4'b0001, 2, 16'h0005, 4'b0000, -1, 16'h0, 4'b0);
    run_frame("E", 16, S5, lz, lz, lz, 4'b0000, 5, 16'h0000, 4'b1010, -1, 16'h0, 4'b0);
    run_frame("F", 16, S0, lz, lz, lz, 4'b1010, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
    run_frame("G", 10, S0, lz, lz, lz, 4'b1010, 1, 16'h7777, 4'b1111, -1, 16'h0, 4'b0);

    // Now mid-slot at idx=2; reset must clear outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    blank_lz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("H", 16, S0, S0, S0, S0, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);
    run_frame("I", 16, S0, S0, S0, S0, 4'b0000, -1, 16'h0, 4'b0, -1, 16'h0, 4'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
